vfu_result_collector: RTL

Downstream consumer of the VFU result interface. It captures every vector presented with out_tvalid into a small vector FIFO, then emits it one FP16 lane at a time on a valid/ready stream toward writeback. The VFU has no backpressure, so this block absorbs bursts and flags any vector it drops.

---
 rtl/vfu_pkg.sv | 18 +
 rtl/vfu_result_collector_if.sv | 28 ++
 rtl/vfu_sync_fifo.sv | 49 ++++
 rtl/vfu_result_collector.sv | 96 +++++++++
 4 files changed

// File: rtl/vfu_pkg.sv
// Shared VFU definitions: lane width, INST tag encodings and result-collector FSM states.
package vfu_pkg;

  localparam int FP16_W = 16;

  typedef enum logic [1:0] {
    VFU_MULT   = 2'b00,
    VFU_ADD    = 2'b01,
    VFU_SUBEXP = 2'b10,
    VFU_BYPASS = 2'b11
  } vfu_inst_e;

  typedef enum logic {
    COL_IDLE = 1'b0,
    COL_SEND = 1'b1
  } col_state_e;

endpackage

// File: rtl/vfu_result_collector_if.sv
// VFU result bus in, per-lane valid/ready stream out; master drives vectors and m_tready,
// slave is the collector.
interface vfu_result_collector_if
  import vfu_pkg::*;
#(
  parameter int N = 4,
  parameter int W = FP16_W
);
  logic                   in_tvalid;
  logic [N*W-1:0]         in_vect_flat;
  logic [1:0]             in_inst;
  logic [W-1:0]           m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;
  logic [1:0]             m_tuser;
  logic [$clog2(N)-1:0]   m_lane;

  modport master (
    output in_tvalid, in_vect_flat, in_inst, m_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tuser, m_lane
  );

  modport slave (
    input  in_tvalid, in_vect_flat, in_inst, m_tready,
    output m_tdata, m_tvalid, m_tlast, m_tuser, m_lane
  );
endinterface

// File: rtl/vfu_sync_fifo.sv
// Synchronous FIFO, registered pointers, head readable combinationally with zero latency.
// full already discounts a same-cycle pop so a producer can refill the slot being vacated.
module vfu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok   = pop && (count != '0);
  assign full     = (count == FULL_CNT) && !pop_ok;
  assign push_ok  = push && !full;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/vfu_result_collector.sv
// Buffers whole VFU result vectors and streams them out lane by lane; lane 0 one cycle after push.
// Holds output under m_tready=0; VFU cannot be stalled, so vectors arriving while full are dropped.
module vfu_result_collector
  import vfu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int W     = FP16_W
) (
  input  logic                    clk,
  input  logic                    rst,
  vfu_result_collector_if.slave   bus,
  input  logic                    clear_ovf,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 + N*W;
  localparam logic [LW-1:0] LAST_LANE = LW'(N-1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  col_state_e     state;
  logic           tvalid_q;
  logic [LW-1:0]  lane;
  logic [EW-1:0]  head;
  logic           full;
  logic           push;
  logic           drop;
  logic           xfer;
  logic           last_xfer;

  assign xfer      = tvalid_q && bus.m_tready;
  assign last_xfer = xfer && (lane == LAST_LANE);
  assign push      = bus.in_tvalid && !full;
  assign drop      = bus.in_tvalid && full;

  vfu_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({bus.in_inst, bus.in_vect_flat}),
    .pop      (last_xfer),
    .head_dat (head),
    .count    (fifo_count),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COL_IDLE;
      tvalid_q <= 1'b0;
      lane     <= '0;
    end else begin
      case (state)
        COL_IDLE: begin
          if (push) begin
            state    <= COL_SEND;
            tvalid_q <= 1'b1;
          end
        end
        COL_SEND: begin
          if (last_xfer) begin
            lane <= '0;
            // Stay in SEND when another vector is queued or arrives now: no bubble between vectors.
            if ((fifo_count == CNT_ONE) && !push) begin
              state    <= COL_IDLE;
              tvalid_q <= 1'b0;
            end
          end else if (xfer) begin
            lane <= lane + 1'b1;
          end
        end
        default: begin
          state    <= COL_IDLE;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  assign bus.m_tvalid = tvalid_q;
  assign bus.m_lane   = lane;
  assign bus.m_tdata  = tvalid_q ? head[lane*W +: W] : '0;
  assign bus.m_tuser  = tvalid_q ? head[EW-1 -: 2] : '0;
  assign bus.m_tlast  = tvalid_q && (lane == LAST_LANE);
endmodule
